// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared constants for the single-precision helper datapath: operation
// codes, resolved rounding modes, FCLASS result bit positions and the
// IEEE-754 single-precision field geometry.
// ---------------------------------------------------------------------------
package fp_pkg;

    // Operation select codes (code 3 is reserved and yields a zero result)
    localparam logic [1:0] OP_FCLASS   = 2'd0;
    localparam logic [1:0] OP_CVT_S_W  = 2'd1;
    localparam logic [1:0] OP_CVT_S_WU = 2'd2;

    // Resolved rounding modes; unused encodings fall back to RNE
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // FCLASS one-hot bit positions
    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;
    localparam int CLS_W        = 10;

    // Single-precision field geometry
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

endpackage

// File: rtl/int_to_f32_round.sv
// ---------------------------------------------------------------------------
// int_to_f32_round
// Combinational integer-to-single conversion with rounding. Shared by the
// signed and unsigned conversion operations; the caller supplies the sign
// and the 32-bit magnitude separately.
//   sign  in   1   sign of the result
//   mag   in  32   unsigned magnitude
//   rm    in   3   resolved rounding mode
//   f     out 32   IEEE-754 single result
//   nx    out  1   result is inexact
// ---------------------------------------------------------------------------
module int_to_f32_round
    import fp_pkg::*;
(
    input  logic        sign,
    input  logic [31:0] mag,
    input  logic [2:0]  rm,
    output logic [31:0] f,
    output logic        nx
);

    logic [4:0]        lead_pos;
    logic [31:0]       norm;
    logic [FRAC_W-1:0] mant;
    logic              guard;
    logic              sticky;
    logic              nx_raw;
    logic              round_inc;
    logic [FRAC_W:0]   mant_sum;
    logic [EXP_W-1:0]  exp_biased;

    // Priority encoder: the last set bit scanned upward wins, giving the
    // position of the most significant one.
    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) begin
                lead_pos = 5'(i);
            end
        end
    end

    // Leading one moves to bit 31; it becomes the implicit bit and the
    // bits below it split into mantissa, guard and sticky.
    assign norm   = mag << (5'd31 - lead_pos);
    assign mant   = norm[30:8];
    assign guard  = norm[7];
    assign sticky = |norm[6:0];
    assign nx_raw = guard | sticky;

    // Rounding increment; undefined encodings behave like RNE.
    always_comb begin
        round_inc = 1'b0;
        case (rm)
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = sign & nx_raw;
            RM_RUP:  round_inc = ~sign & nx_raw;
            RM_RMM:  round_inc = guard;
            default: round_inc = guard & (sticky | mant[0]);
        endcase
    end

    // A carry out of the mantissa leaves the low bits all zero and bumps
    // the exponent; the largest exponent reachable is 159, so no overflow.
    assign mant_sum   = {1'b0, mant} + {{FRAC_W{1'b0}}, round_inc};
    assign exp_biased = EXP_W'(BIAS) + {3'b000, lead_pos}
                        + {{(EXP_W-1){1'b0}}, mant_sum[FRAC_W]};

    // Zero has no leading one and always maps to +0 exactly.
    always_comb begin
        f  = '0;
        nx = 1'b0;
        if (mag != '0) begin
            f  = {sign, exp_biased, mant_sum[FRAC_W-1:0]};
            nx = nx_raw;
        end
    end

endmodule

// File: rtl/fp_int_class_unit.sv
// ---------------------------------------------------------------------------
// fp_int_class_unit
// FCLASS.S, FCVT.S.W and FCVT.S.WU with a one-cycle registered result.
//   clk        in   1   rising-edge clock
//   resetn     in   1   synchronous reset, active HIGH despite the name
//   valid_in   in   1   request strobe
//   op         in   2   0 FCLASS, 1 CVT.S.W, 2 CVT.S.WU, 3 reserved
//   rm         in   3   resolved rounding mode
//   rs1        in  32   operand (float for FCLASS, integer for converts)
//   valid_out  out  1   one-cycle pulse per accepted request
//   result     out 32   registered result
//   fflag_nx   out  1   inexact flag for the presented result
// ---------------------------------------------------------------------------
module fp_int_class_unit
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_in,
    input  logic [1:0]  op,
    input  logic [2:0]  rm,
    input  logic [31:0] rs1,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        fflag_nx
);

    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W-1:0] in_frac;
    logic [CLS_W-1:0]  class_onehot;
    logic              cvt_sign;
    logic [31:0]       cvt_mag;
    logic [31:0]       cvt_f;
    logic              cvt_nx;
    logic [31:0]       next_result;
    logic              next_nx;

    assign in_sign = rs1[31];
    assign in_exp  = rs1[30:23];
    assign in_frac = rs1[22:0];

    // FCLASS decode: exactly one category bit is set for every input.
    always_comb begin
        class_onehot = '0;
        if (in_exp == '1) begin
            if (in_frac == '0) begin
                class_onehot[in_sign ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            end else if (in_frac[FRAC_W-1]) begin
                class_onehot[CLS_QNAN] = 1'b1;
            end else begin
                class_onehot[CLS_SNAN] = 1'b1;
            end
        end else if (in_exp == '0) begin
            if (in_frac == '0) begin
                class_onehot[in_sign ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            end else begin
                class_onehot[in_sign ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
            end
        end else begin
            class_onehot[in_sign ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end

    // Only the signed conversion looks at rs1[31]; negating the most
    // negative integer wraps to 0x80000000, which is the correct magnitude.
    assign cvt_sign = (op == OP_CVT_S_W) & rs1[31];
    assign cvt_mag  = cvt_sign ? (~rs1 + 32'd1) : rs1;

    int_to_f32_round u_round (
        .sign (cvt_sign),
        .mag  (cvt_mag),
        .rm   (rm),
        .f    (cvt_f),
        .nx   (cvt_nx)
    );

    // Operation mux; the reserved code produces zero with no flag.
    always_comb begin
        next_result = '0;
        next_nx     = 1'b0;
        case (op)
            OP_FCLASS: begin
                next_result = {{(32-CLS_W){1'b0}}, class_onehot};
                next_nx     = 1'b0;
            end
            OP_CVT_S_W, OP_CVT_S_WU: begin
                next_result = cvt_f;
                next_nx     = cvt_nx;
            end
            default: begin
                next_result = '0;
                next_nx     = 1'b0;
            end
        endcase
    end

    // Output registers: reset wins over a same-cycle request, and the
    // result holds its last value while no request arrives.
    always_ff @(posedge clk) begin
        if (resetn) begin
            valid_out <= 1'b0;
            result    <= '0;
            fflag_nx  <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                result   <= next_result;
                fflag_nx <= next_nx;
            end
        end
    end

endmodule

// File: tb/tb_fp_int_class_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_int_class_unit
// Scoreboard bench: each request pushes its expected result, which is popped
// and compared one cycle later when the DUT presents it.
// ---------------------------------------------------------------------------
module tb_fp_int_class_unit;
    import fp_pkg::*;

    logic        clk;
    logic        resetn;
    logic        valid_in;
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [31:0] rs1;
    logic        valid_out;
    logic [31:0] result;
    logic        fflag_nx;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  rm;
        logic [31:0] a;
        logic [31:0] res;
        logic        nx;
    } req_t;

    typedef struct {
        logic [31:0] res;
        logic        nx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fp_int_class_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .valid_in  (valid_in),
        .op        (op),
        .rm        (rm),
        .rs1       (rs1),
        .valid_out (valid_out),
        .result    (result),
        .fflag_nx  (fflag_nx)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset for two edges, then confirm the cleared output state
    task automatic test_reset();
        resetn   = 1'b1;
        valid_in = 1'b0;
        op       = OP_FCLASS;
        rm       = RM_RNE;
        rs1      = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || result !== 32'h0 || fflag_nx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset got v=%0b res=%h nx=%0b want v=0 res=00000000 nx=0",
                     valid_out, result, fflag_nx);
        end
        resetn = 1'b0;
    endtask

    // FCLASS sweep over every category, issued back to back
    task automatic test_fclass();
        req_t t[$];
        exp_t e;
        t.push_back('{OP_FCLASS, RM_RNE, 32'hFF800000, 32'h001, 1'b0});
        t.push_back('{OP_FCLASS, RM_RTZ, 32'hBF800000, 32'h002, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h80000001, 32'h004, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h807FFFFF, 32'h004, 1'b0});
        t.push_back('{OP_FCLASS, RM_RUP, 32'h80000000, 32'h008, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h00000000, 32'h010, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h00000001, 32'h020, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h3F800000, 32'h040, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h7F7FFFFF, 32'h040, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h7F800000, 32'h080, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h7F800001, 32'h100, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'hFF800001, 32'h100, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'h7FC00000, 32'h200, 1'b0});
        t.push_back('{OP_FCLASS, RM_RNE, 32'hFFC00000, 32'h200, 1'b0});
        for (int i = 0; i <= t.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (valid_out !== 1'b1 || result !== e.res || fflag_nx !== e.nx) begin
                    errors++;
                    $display("[TB] FAIL fclass[%0d] in=%h got v=%0b res=%h nx=%0b want v=1 res=%h nx=%0b",
                             i-1, t[i-1].a, valid_out, result, fflag_nx, e.res, e.nx);
                end
            end
            if (i < t.size()) begin
                valid_in = 1'b1;
                op       = t[i].op;
                rm       = t[i].rm;
                rs1      = t[i].a;
                sb.push_back('{t[i].res, t[i].nx});
            end else begin
                valid_in = 1'b0;
            end
        end
    endtask

    // Conversions: exact values, ties, carry into exponent, all modes
    task automatic test_convert();
        req_t t[$];
        exp_t e;
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'h00000000, 32'h00000000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'h00000001, 32'h3F800000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'hFFFFFFFF, 32'hBF800000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'h80000000, 32'hCF000000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RTZ, 32'h00000003, 32'h40400000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'hFFFFFFFB, 32'hC0A00000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'd16777217, 32'h4B800000, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RUP, 32'd16777217, 32'h4B800001, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RTZ, 32'd16777217, 32'h4B800000, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RMM, 32'd16777217, 32'h4B800001, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RDN, 32'd16777217, 32'h4B800000, 1'b1});
        t.push_back('{OP_CVT_S_W,  3'b111, 32'd16777217, 32'h4B800000, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'd16777219, 32'h4B800002, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RDN, 32'hFEFFFFFF, 32'hCB800001, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RUP, 32'hFEFFFFFF, 32'hCB800000, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RMM, 32'hFEFFFFFF, 32'hCB800001, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'h7FFFFFFF, 32'h4F000000, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RDN, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1});
        t.push_back('{OP_CVT_S_WU, RM_RNE, 32'hFFFFFFFF, 32'h4F800000, 1'b1});
        t.push_back('{OP_CVT_S_WU, RM_RTZ, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'hFFFFFFFF, 32'hBF800000, 1'b0});
        t.push_back('{OP_CVT_S_WU, RM_RNE, 32'h80000000, 32'h4F000000, 1'b0});
        t.push_back('{OP_CVT_S_WU, RM_RNE, 32'h00000000, 32'h00000000, 1'b0});
        t.push_back('{2'd3,        RM_RNE, 32'hFFFFFFFF, 32'h00000000, 1'b0});
        for (int i = 0; i <= t.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (valid_out !== 1'b1 || result !== e.res || fflag_nx !== e.nx) begin
                    errors++;
                    $display("[TB] FAIL convert[%0d] op=%0d rm=%0d in=%h got v=%0b res=%h nx=%0b want v=1 res=%h nx=%0b",
                             i-1, t[i-1].op, t[i-1].rm, t[i-1].a, valid_out, result, fflag_nx, e.res, e.nx);
                end
            end
            if (i < t.size()) begin
                valid_in = 1'b1;
                op       = t[i].op;
                rm       = t[i].rm;
                rs1      = t[i].a;
                sb.push_back('{t[i].res, t[i].nx});
            end else begin
                valid_in = 1'b0;
            end
        end
    endtask

    // Mixed operations on consecutive cycles, then idle cycles that must
    // hold the last result with valid_out low
    task automatic test_back_to_back();
        req_t t[$];
        exp_t e;
        t.push_back('{OP_CVT_S_WU, RM_RNE, 32'hFFFFFFFF, 32'h4F800000, 1'b1});
        t.push_back('{OP_FCLASS,   RM_RNE, 32'h7FC00000, 32'h00000200, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RUP, 32'd16777217, 32'h4B800001, 1'b1});
        t.push_back('{OP_CVT_S_W,  RM_RNE, 32'h00000001, 32'h3F800000, 1'b0});
        t.push_back('{OP_CVT_S_W,  RM_RMM, 32'd16777217, 32'h4B800001, 1'b1});
        for (int i = 0; i <= t.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb.pop_front();
                checks++;
                if (valid_out !== 1'b1 || result !== e.res || fflag_nx !== e.nx) begin
                    errors++;
                    $display("[TB] FAIL b2b[%0d] got v=%0b res=%h nx=%0b want v=1 res=%h nx=%0b",
                             i-1, valid_out, result, fflag_nx, e.res, e.nx);
                end
            end
            if (i < t.size()) begin
                valid_in = 1'b1;
                op       = t[i].op;
                rm       = t[i].rm;
                rs1      = t[i].a;
                sb.push_back('{t[i].res, t[i].nx});
            end else begin
                valid_in = 1'b0;
                rs1      = 32'h12345678;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (valid_out !== 1'b0 || result !== 32'h4B800001 || fflag_nx !== 1'b1) begin
                errors++;
                $display("[TB] FAIL idle_hold[%0d] got v=%0b res=%h nx=%0b want v=0 res=4b800001 nx=1",
                         k, valid_out, result, fflag_nx);
            end
        end
    endtask

    // Reset asserted together with a request: the request is dropped
    task automatic test_reset_priority();
        exp_t e;
        @(negedge clk);
        valid_in = 1'b1;
        op       = OP_CVT_S_W;
        rm       = RM_RNE;
        rs1      = 32'hFFFFFFFF;
        sb.push_back('{32'hBF800000, 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (valid_out !== 1'b1 || result !== e.res || fflag_nx !== e.nx) begin
            errors++;
            $display("[TB] FAIL pre_reset got v=%0b res=%h nx=%0b want v=1 res=%h nx=%0b",
                     valid_out, result, fflag_nx, e.res, e.nx);
        end
        resetn   = 1'b1;
        valid_in = 1'b1;
        op       = OP_CVT_S_WU;
        rm       = RM_RNE;
        rs1      = 32'hFFFFFFFF;
        @(negedge clk);
        resetn   = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || result !== 32'h0 || fflag_nx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_priority got v=%0b res=%h nx=%0b want v=0 res=00000000 nx=0",
                     valid_out, result, fflag_nx);
        end
        @(negedge clk);
        checks++;
        if (valid_out !== 1'b0 || result !== 32'h0 || fflag_nx !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got v=%0b res=%h nx=%0b want v=0 res=00000000 nx=0",
                     valid_out, result, fflag_nx);
        end
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_fclass();
        test_convert();
        test_back_to_back();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
